// File: rtl/bubsys_color_lut_if.sv
// bubsys_color_lut_if
// Groups the ROM/table download port (ioctl_*).
// master: the download source drives every signal.
// slave : the colour LUT block samples every signal.
//   ioctl_download  download-active flag
//   ioctl_index     download index; selects which table is loaded
//   ioctl_addr      byte address within the download
//   ioctl_data      byte value
//   ioctl_wr        write strobe, one cycle per byte
interface bubsys_color_lut_if;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;

  modport master (
    output ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr
  );

  modport slave (
    input ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr
  );
endinterface

// File: rtl/bubsys_color_lut.sv
// bubsys_color_lut
// Converts IN_BITS-per-channel pixel colour to 8 bits per channel. The
// conversion can use a builtin resistor-network table, bit replication, a
// user table loaded over the ioctl download port, or zero padding.
// The mode is applied only at a vblank rise, so a frame never mixes modes.
//
// Ports
//   i_EMU_CLK72M    clock
//   i_EMU_SOFTRST   synchronous active-high reset
//   i_MODE          requested mode (0 builtin, 1 replicate, 2 user, 3 zero-pad)
//   i_CE_PIX        pixel clock enable; the datapath advances only when it is high
//   i_RGB           input colour, channel 0 (R) in the MSB field
//   i_H/VBLANK, i_H/VSYNC   raw timing
//   ioctl           download port (slave modport)
//   o_RGB           converted colour, 2 pixel enables after the input
//   o_H/VBLANK, o_H/VSYNC   timing delayed to match o_RGB
//   o_LUT_VALID     a complete user table is resident
//   o_LUT_ERR       the last download was rejected
//   o_MODE_ACTIVE   mode currently applied
//
// Load FSM
//   state | meaning
//   IDLE  | no download seen since reset
//   LOAD  | accepting in-order bytes of the user table
//   DONE  | download finished; valid/err show the result
module bubsys_color_lut #(
  parameter int          IN_BITS    = 5,
  parameter int          CHANNELS   = 3,
  parameter logic [15:0] LUT_INDEX  = 16'd3,
  parameter bit          BLANK_ZERO = 1'b1
) (
  input  logic                         i_EMU_CLK72M,
  input  logic                         i_EMU_SOFTRST,
  input  logic [1:0]                   i_MODE,
  input  logic                         i_CE_PIX,
  input  logic [CHANNELS*IN_BITS-1:0]  i_RGB,
  input  logic                         i_HBLANK,
  input  logic                         i_VBLANK,
  input  logic                         i_HSYNC,
  input  logic                         i_VSYNC,
  bubsys_color_lut_if.slave            ioctl,
  output logic [CHANNELS*8-1:0]        o_RGB,
  output logic                         o_HBLANK,
  output logic                         o_VBLANK,
  output logic                         o_HSYNC,
  output logic                         o_VSYNC,
  output logic                         o_LUT_VALID,
  output logic                         o_LUT_ERR,
  output logic [1:0]                   o_MODE_ACTIVE
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int SIZE   = CHANNELS * DEPTH;
  localparam int CNT_W  = $clog2(SIZE + 1);
  localparam int BANK_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_t;

  function automatic logic [7:0] builtin5(input logic [4:0] idx);
    logic [7:0] r;
    case (idx)
      5'd0:  r = 8'h00;  5'd1:  r = 8'h01;  5'd2:  r = 8'h02;  5'd3:  r = 8'h04;
      5'd4:  r = 8'h05;  5'd5:  r = 8'h06;  5'd6:  r = 8'h08;  5'd7:  r = 8'h09;
      5'd8:  r = 8'h0B;  5'd9:  r = 8'h0D;  5'd10: r = 8'h0F;  5'd11: r = 8'h12;
      5'd12: r = 8'h14;  5'd13: r = 8'h16;  5'd14: r = 8'h19;  5'd15: r = 8'h1C;
      5'd16: r = 8'h21;  5'd17: r = 8'h24;  5'd18: r = 8'h29;  5'd19: r = 8'h2E;
      5'd20: r = 8'h33;  5'd21: r = 8'h39;  5'd22: r = 8'h40;  5'd23: r = 8'h49;
      5'd24: r = 8'h50;  5'd25: r = 8'h5B;  5'd26: r = 8'h68;  5'd27: r = 8'h78;
      5'd28: r = 8'h8E;  5'd29: r = 8'hA8;  5'd30: r = 8'hCC;  default: r = 8'hFF;
    endcase
    return r;
  endfunction

  // Repeat the input MSB-first until 8 bits are filled.
  function automatic logic [7:0] replicate(input logic [IN_BITS-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[7-k] = v[IN_BITS-1-(k % IN_BITS)];
    end
    return r;
  endfunction

  function automatic logic [7:0] zero_pad(input logic [IN_BITS-1:0] v);
    return 8'(v) << (8 - IN_BITS);
  endfunction

  // ---------------------------------------------------------------- load FSM
  load_state_t      state, state_next;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_next;
  logic             err_q, err_next;
  logic             valid_next, lut_err_next;
  logic             dl_prev;
  logic             dl_start;
  logic             in_range, in_order;
  logic             ram_we;
  logic [BANK_W-1:0]  wr_bank;
  logic [IN_BITS-1:0] wr_entry;

  assign dl_start = ioctl.ioctl_download & ~dl_prev & (ioctl.ioctl_index == LUT_INDEX);
  assign in_range = ioctl.ioctl_addr < 27'(SIZE);
  assign in_order = ioctl.ioctl_addr == 27'(wr_cnt);
  assign wr_bank  = ioctl.ioctl_addr[IN_BITS +: BANK_W];
  assign wr_entry = ioctl.ioctl_addr[IN_BITS-1:0];

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      err_q       <= 1'b0;
      o_LUT_VALID <= 1'b0;
      o_LUT_ERR   <= 1'b0;
      // Treat the flag as already high so a download that straddles reset
      // is not mistaken for a fresh one; it must fall and rise again.
      dl_prev     <= 1'b1;
    end else begin
      state       <= state_next;
      wr_cnt      <= wr_cnt_next;
      err_q       <= err_next;
      o_LUT_VALID <= valid_next;
      o_LUT_ERR   <= lut_err_next;
      dl_prev     <= ioctl.ioctl_download;
    end
  end

  always_comb begin
    state_next   = state;
    wr_cnt_next  = wr_cnt;
    err_next     = err_q;
    valid_next   = o_LUT_VALID;
    lut_err_next = o_LUT_ERR;
    ram_we       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (dl_start) begin
          state_next   = LOAD;
          wr_cnt_next  = '0;
          err_next     = 1'b0;
          valid_next   = 1'b0;
          lut_err_next = 1'b0;
        end
      end
      LOAD: begin
        if (ioctl.ioctl_wr && in_range) begin
          if (in_order) begin
            ram_we      = 1'b1;
            wr_cnt_next = wr_cnt + 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        // The completeness check uses the post-write count so a final byte
        // arriving with the falling edge is included.
        if (!ioctl.ioctl_download) begin
          state_next = DONE;
          if ((wr_cnt_next == CNT_W'(SIZE)) && !err_next) begin
            valid_next   = 1'b1;
            lut_err_next = 1'b0;
          end else begin
            valid_next   = 1'b0;
            lut_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------ mode latch
  logic vblank_prev;

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      o_MODE_ACTIVE <= 2'd0;
      vblank_prev   <= 1'b0;
    end else if (i_CE_PIX) begin
      vblank_prev <= i_VBLANK;
      if (i_VBLANK && !vblank_prev) o_MODE_ACTIVE <= i_MODE;
    end
  end

  logic [1:0] mode_eff;

  always_comb begin
    mode_eff = o_MODE_ACTIVE;
    if (mode_eff == 2'd2 && !o_LUT_VALID) mode_eff = 2'd0;
    if (mode_eff == 2'd0 && IN_BITS != 5) mode_eff = 2'd1;
  end

  // ---------------------------------------------------------- stage 1
  logic [CHANNELS*IN_BITS-1:0] s1_rgb;
  logic s1_hblank, s1_vblank, s1_hsync, s1_vsync;

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      s1_rgb    <= '0;
      s1_hblank <= 1'b1;
      s1_vblank <= 1'b1;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
    end else if (i_CE_PIX) begin
      s1_rgb    <= i_RGB;
      s1_hblank <= i_HBLANK;
      s1_vblank <= i_VBLANK;
      s1_hsync  <= i_HSYNC;
      s1_vsync  <= i_VSYNC;
    end
  end

  // One RAM bank per channel: one write port from the loader, one read port
  // from the pixel path. The read sits alongside the stage-1 registers.
  logic [CHANNELS*8-1:0] conv;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]         mem [DEPTH];
    logic [7:0]         rd_q;
    logic [IN_BITS-1:0] rd_idx;
    logic [IN_BITS-1:0] v;
    logic [7:0]         out_c;

    assign rd_idx = i_RGB[(CHANNELS-1-c)*IN_BITS +: IN_BITS];
    assign v      = s1_rgb[(CHANNELS-1-c)*IN_BITS +: IN_BITS];

    // Nonblocking write and read in one block: a same-address collision
    // returns the previous contents.
    always_ff @(posedge i_EMU_CLK72M) begin
      if (ram_we && wr_bank == BANK_W'(c)) mem[wr_entry] <= ioctl.ioctl_data;
      if (i_CE_PIX) rd_q <= mem[rd_idx];
    end

    always_comb begin
      out_c = '0;
      case (mode_eff)
        2'd0:    out_c = builtin5(5'(v));
        2'd1:    out_c = replicate(v);
        2'd2:    out_c = rd_q;
        default: out_c = zero_pad(v);
      endcase
    end

    assign conv[(CHANNELS-1-c)*8 +: 8] = out_c;
  end

  // ---------------------------------------------------------- stage 2
  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_SOFTRST) begin
      o_RGB    <= '0;
      o_HBLANK <= 1'b1;
      o_VBLANK <= 1'b1;
      o_HSYNC  <= 1'b0;
      o_VSYNC  <= 1'b0;
    end else if (i_CE_PIX) begin
      o_RGB    <= (BLANK_ZERO && (s1_hblank || s1_vblank)) ? '0 : conv;
      o_HBLANK <= s1_hblank;
      o_VBLANK <= s1_vblank;
      o_HSYNC  <= s1_hsync;
      o_VSYNC  <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_bubsys_color_lut.sv
module tb_bubsys_color_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        ce;
  logic [14:0] rgb;
  logic        hb, vb, hs, vs;
  logic [23:0] o_rgb;
  logic        o_hb, o_vb, o_hs, o_vs;
  logic        valid, lerr;
  logic [1:0]  mact;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bubsys_color_lut_if bus ();

  bubsys_color_lut #(
    .IN_BITS(5), .CHANNELS(3), .LUT_INDEX(16'd3), .BLANK_ZERO(1'b1)
  ) dut (
    .i_EMU_CLK72M (clk),
    .i_EMU_SOFTRST(rst),
    .i_MODE       (mode),
    .i_CE_PIX     (ce),
    .i_RGB        (rgb),
    .i_HBLANK     (hb),
    .i_VBLANK     (vb),
    .i_HSYNC      (hs),
    .i_VSYNC      (vs),
    .ioctl        (bus),
    .o_RGB        (o_rgb),
    .o_HBLANK     (o_hb),
    .o_VBLANK     (o_vb),
    .o_HSYNC      (o_hs),
    .o_VSYNC      (o_vs),
    .o_LUT_VALID  (valid),
    .o_LUT_ERR    (lerr),
    .o_MODE_ACTIVE(mact)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [14:0] c, input logic h, input logic v, input logic s);
    ce = 1'b1; rgb = c; hb = h; vb = v; hs = s;
    step();
  endtask

  task automatic latch_mode(input logic [1:0] m);
    mode = m;
    pix(15'd0, 1'b0, 1'b1, 1'b0);
    pix(15'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic show(input string tag, input logic [14:0] c, input logic [23:0] exp);
    pix(c, 1'b0, 1'b0, 1'b0);
    pix(15'd0, 1'b0, 1'b0, 1'b0);
    check(tag, 32'(o_rgb), 32'(exp));
  endtask

  task automatic dl_begin(input logic [15:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    step();
  endtask

  task automatic dl_wr(input int a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 27'(a); bus.ioctl_data = d;
    step();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic dl_end();
    bus.ioctl_download = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd2; ce = 1'b1; rgb = 15'h7FFF;
    hb = 1'b0; vb = 1'b0; hs = 1'b1; vs = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_index = 16'd0;
    bus.ioctl_addr = '0; bus.ioctl_data = 8'd0; bus.ioctl_wr = 1'b0;
    step(); step();

    // reset state
    check("rst_rgb",    32'(o_rgb), 32'h0);
    check("rst_hblank", 32'(o_hb),  32'd1);
    check("rst_vblank", 32'(o_vb),  32'd1);
    check("rst_hsync",  32'(o_hs),  32'd0);
    check("rst_vsync",  32'(o_vs),  32'd0);
    check("rst_mode",   32'(mact),  32'd0);
    check("rst_valid",  32'(valid), 32'd0);
    check("rst_err",    32'(lerr),  32'd0);
    rst = 1'b0; hs = 1'b0; vs = 1'b0;

    // builtin table, exact 2-enable latency, sync aligned
    latch_mode(2'd0);
    check("mode0_latched", 32'(mact), 32'd0);
    ce = 1'b1; rgb = {5'd31, 5'd16, 5'd0}; hb = 1'b0; vb = 1'b0; hs = 1'b1;
    step();
    check("lat_one_enable_rgb",  32'(o_rgb), 32'h000000);
    check("lat_one_enable_sync", 32'(o_hs),  32'd0);
    rgb = 15'd0; hs = 1'b0;
    step();
    check("lat_two_enable_rgb",  32'(o_rgb), 32'hFF2100);
    check("lat_two_enable_sync", 32'(o_hs),  32'd1);

    // mode request mid-line is deferred to the next vblank rise
    mode = 2'd1;
    show("midline_still_builtin", {5'd22, 5'd0, 5'd31}, 24'h4000FF);
    check("midline_mode_held", 32'(mact), 32'd0);
    latch_mode(2'd1);
    check("mode1_latched", 32'(mact), 32'd1);
    show("mode1_replicate", {5'b10110, 5'd5, 5'd31}, 24'hB529FF);
    latch_mode(2'd3);
    show("mode3_zero_pad", {5'b10110, 5'd5, 5'd31}, 24'hB028F8);

    // mode 2 before any table: builtin
    latch_mode(2'd2);
    show("mode2_no_table", {5'd22, 5'd5, 5'd31}, 24'h4006FF);

    // good download; final byte coincides with the download falling edge,
    // plus one out-of-range write that must be ignored silently
    ce = 1'b0;
    dl_begin(16'd3);
    for (int a = 0; a < 95; a++) begin
      if (a == 40) dl_wr(500, 8'h77);
      dl_wr(a, 8'(a));
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 27'd95; bus.ioctl_data = 8'd95;
    bus.ioctl_download = 1'b0;
    step();
    bus.ioctl_wr = 1'b0;
    check("good_dl_valid", 32'(valid), 32'd1);
    check("good_dl_err",   32'(lerr),  32'd0);
    show("mode2_user_table", {5'd22, 5'd5, 5'd31}, 24'h16255F);

    // non-matching index is ignored
    ce = 1'b0;
    dl_begin(16'd5);
    dl_wr(22, 8'hEE);
    check("other_idx_valid_kept", 32'(valid), 32'd1);
    dl_end();
    check("other_idx_err", 32'(lerr), 32'd0);
    show("other_idx_ram_kept", {5'd22, 5'd5, 5'd31}, 24'h16255F);

    // download with address 7 skipped
    ce = 1'b0;
    dl_begin(16'd3);
    check("load_valid_cleared", 32'(valid), 32'd0);
    show("load_fallback_builtin", {5'd22, 5'd5, 5'd31}, 24'h4006FF);
    ce = 1'b0;
    for (int a = 0; a < 96; a++) begin
      if (a != 7) dl_wr(a, 8'(a) ^ 8'hFF);
    end
    dl_end();
    check("skip_dl_err",   32'(lerr),  32'd1);
    check("skip_dl_valid", 32'(valid), 32'd0);
    show("skip_dl_builtin", {5'd22, 5'd5, 5'd31}, 24'h4006FF);

    // reset at byte 40 of a download
    ce = 1'b0;
    dl_begin(16'd3);
    for (int a = 0; a < 40; a++) dl_wr(a, 8'(a) + 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_err",   32'(lerr),  32'd0);
    check("midrst_mode",  32'(mact),  32'd0);
    for (int a = 40; a < 96; a++) dl_wr(a, 8'(a) ^ 8'hAA);
    dl_end();
    check("midrst_tail_valid", 32'(valid), 32'd0);
    check("midrst_tail_err",   32'(lerr),  32'd0);
    dl_begin(16'd3);
    for (int a = 0; a < 96; a++) dl_wr(a, 8'(a) + 8'd1);
    dl_end();
    check("fresh_dl_valid", 32'(valid), 32'd1);
    check("fresh_dl_err",   32'(lerr),  32'd0);
    latch_mode(2'd2);
    show("fresh_dl_table", {5'd22, 5'd5, 5'd31}, 24'h172660);

    // pixel enable 1-of-4 under hblank: zeroed colour, aligned sync, hold
    for (int g = 0; g < 2; g++) begin
      pix(15'h7FFF, 1'b1, 1'b0, 1'b0);
      ce = 1'b0; hs = 1'b1; rgb = 15'h1234;
      step(); step(); step();
    end
    check("ce_blank_rgb",    32'(o_rgb), 32'h0);
    check("ce_blank_hblank", 32'(o_hb),  32'd1);
    check("ce_blank_vblank", 32'(o_vb),  32'd0);
    check("ce_pre_hsync",    32'(o_hs),  32'd0);
    pix(15'h7FFF, 1'b1, 1'b0, 1'b1);
    check("ce_a_hsync", 32'(o_hs), 32'd0);
    ce = 1'b0; hs = 1'b0;
    step(); step(); step();
    check("ce_a_hold_hsync", 32'(o_hs), 32'd0);
    pix(15'h7FFF, 1'b1, 1'b0, 1'b0);
    check("ce_b_hsync",  32'(o_hs),  32'd1);
    check("ce_b_rgb",    32'(o_rgb), 32'h0);
    ce = 1'b0; hs = 1'b1; hb = 1'b0;
    step(); step(); step();
    check("ce_b_hold_hsync", 32'(o_hs), 32'd1);
    check("ce_b_hold_rgb",   32'(o_rgb), 32'h0);
    pix(15'h7FFF, 1'b1, 1'b0, 1'b0);
    check("ce_c_hsync", 32'(o_hs), 32'd0);
    check("ce_c_rgb",   32'(o_rgb), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
